// File: rtl/mult_accumulator.sv
// Saturating burst accumulator fed by the 4x4 Wallace tree product.
// Registers each accepted product once, then adds it into acc on the next edge.
module mult_accumulator #(
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       p_q, p_d;
  logic             pv_q, pv_d;
  logic [ACC_W:0]   sum;
  logic             beat;

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    p_d     = p_q;
    pv_d    = pv_q;
    beat    = in_valid & in_ready;
    sum     = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, p_q};

    // extra carry bit marks saturation
    if ((state_q == ACC || state_q == DRAIN) && pv_q) begin
      if (sum[ACC_W]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = (len == 4'd0) ? 5'd16 : {1'b0, len};
          acc_d   = '0;
          ovf_d   = 1'b0;
          pv_d    = 1'b0;
          state_d = ACC;
        end
      end
      ACC: begin
        pv_d = beat;
        if (beat) begin
          p_d   = prod;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        pv_d    = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      p_q     <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      p_q     <= p_d;
      pv_q    <= pv_d;
    end
  end

endmodule
